// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, instruction field positions, fetch states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package isa_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_NOT = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b0111;
   localparam logic [3:0] OP_LD  = 4'b1000;
   localparam logic [3:0] OP_SD  = 4'b1010;
   localparam logic [3:0] OP_BNE = 4'b1110;
   localparam logic [3:0] OP_JMP = 4'b1111;

   // Opcode field inside the 32-bit instruction word
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Fetch/issue bus: imem req/ack side, decode valid/ready side, control feedback.
// Latency: n/a (wires only).
// Backpressure: imem via imem_ack, decode via decode_ready.
interface instr_fetch_issue_if #(
   parameter int PC_W = 16
) ();
   // instruction memory side
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   // decode side
   logic [3:0]      Opcode;
   logic [31:0]     instr;
   logic            instr_valid;
   logic            decode_ready;
   logic [PC_W-1:0] pc_out;
   // control unit / datapath feedback, sampled on issue
   logic            Jump;
   logic            Branch;
   logic            branch_taken;

   // the fetch unit
   modport master (
      output imem_req, imem_addr, Opcode, instr, instr_valid, pc_out,
      input  imem_ack, imem_rdata, decode_ready, Jump, Branch, branch_taken
   );

   // memory + decode/control environment
   modport slave (
      input  imem_req, imem_addr, Opcode, instr, instr_valid, pc_out,
      output imem_ack, imem_rdata, decode_ready, Jump, Branch, branch_taken
   );
endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump target, taken-branch pc+1+sext(imm16), else pc+1.
// Latency: combinational.
// Backpressure: none; the caller decides when to load the result.
module next_pc_sel #(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_jmp_tgt,
   input  logic [15:0]     i_imm,
   input  logic            i_jump,
   input  logic            i_branch,
   input  logic            i_taken,
   output logic [PC_W-1:0] o_next_pc
);

   // sign-extend bit 15 past PC_W, then keep the low PC_W bits (wraps for any PC_W)
   logic [PC_W+15:0] w_imm_ext;
   logic [PC_W-1:0]  w_offset;
   logic [PC_W-1:0]  w_seq_pc;

   assign w_imm_ext = {{PC_W{i_imm[15]}}, i_imm};
   assign w_offset  = w_imm_ext[PC_W-1:0];
   assign w_seq_pc  = i_pc + PC_W'(1);

   // jump beats branch; all sums are modulo 2^PC_W
   always_comb begin
      o_next_pc = w_seq_pc;
      if (i_jump)
         o_next_pc = i_jmp_tgt;
      else if (i_branch && i_taken)
         o_next_pc = w_seq_pc + w_offset;
   end

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: holds PC, fetches from imem (req/ack), issues to decode (valid/ready).
// Latency: >=1 cycle from entering S_REQ to instr_valid; one issue per 2 cycles at best.
// Backpressure: req/addr held until imem_ack; instr/Opcode/pc_out held until decode_ready.
module instr_fetch_issue
   import isa_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   instr_fetch_issue_if.master bus
);

   fetch_state_t    r_state;
   logic [PC_W-1:0] r_pc;
   logic [31:0]     r_instr;
   logic            r_imem_req;
   logic            r_instr_valid;
   logic [PC_W-1:0] w_next_pc;

   next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
      .i_pc      (r_pc),
      .i_jmp_tgt (r_instr[PC_W-1:0]),
      .i_imm     (r_instr[15:0]),
      .i_jump    (bus.Jump),
      .i_branch  (bus.Branch),
      .i_taken   (bus.branch_taken),
      .o_next_pc (w_next_pc)
   );

   assign bus.imem_req    = r_imem_req;
   assign bus.imem_addr   = r_pc;
   assign bus.pc_out      = r_pc;
   assign bus.instr       = r_instr;
   assign bus.Opcode      = r_instr[OPC_MSB:OPC_LSB];
   assign bus.instr_valid = r_instr_valid;

   // fetch FSM; req/valid are registered alongside the state so they track it exactly
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state    <= S_REQ;
                  r_imem_req <= 1'b1;
               end
            end
            S_REQ: begin
               // run is deliberately ignored here: a started fetch always completes
               if (bus.imem_ack) begin
                  r_instr       <= bus.imem_rdata;
                  r_state       <= S_ISSUE;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               // control feedback only matters in the handshake cycle
               if (bus.decode_ready) begin
                  r_pc          <= w_next_pc;
                  r_instr_valid <= 1'b0;
                  if (run) begin
                     r_state    <= S_REQ;
                     r_imem_req <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: scoreboard on fetch/issue plus next-PC vector table.
// Latency: n/a.
// Backpressure: bench drives imem_ack delays and decode_ready stalls.
module tb_instr_fetch_issue;
   import isa_pkg::*;

   localparam int PC_W = 16;

   logic clk = 1'b0;
   logic reset;
   logic run;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   iss_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_fetch_issue_if #(.PC_W(PC_W)) bus ();

   instr_fetch_issue #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] addr;
      logic [31:0] word;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic [15:0] pc;
      logic [31:0] word;
      logic        j;
      logic        b;
      logic        t;
      logic [15:0] exp_next;
   } vec_t;

   logic [15:0] exp_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // bounded wait for imem_req, checked at negedge
   task automatic wait_req();
      for (int i = 0; i < 50; i++) begin
         if (bus.imem_req === 1'b1) return;
         @(negedge clk);
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: imem_req never rose within 50 cycles (cycle %0d)", cyc);
   endtask

   // reference next-PC for PC_W=16
   function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [31:0] w,
                                              input logic j, input logic b, input logic t);
      if (j) return w[15:0];
      if (b && t) return pc + 16'd1 + w[15:0];
      return pc + 16'd1;
   endfunction

   // expects S_ISSUE at the current negedge; handshakes one cycle
   task automatic issue(input logic j, input logic b, input logic t);
      sb_t e;
      chk("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_empty: issue with no expected entry (cycle %0d)", cyc);
      end else begin
         e = sb.pop_front();
         chk("issue_instr", bus.instr, e.word);
         chk("issue_pc_out", {16'd0, bus.pc_out}, {16'd0, e.addr});
         chk("issue_opcode", {28'd0, bus.Opcode}, {28'd0, e.word[31:28]});
      end
      bus.decode_ready = 1'b1;
      bus.Jump = j;
      bus.Branch = b;
      bus.branch_taken = t;
      iss_cyc = cyc;
      @(negedge clk);
      bus.decode_ready = 1'b0;
      bus.Jump = 1'b0;
      bus.Branch = 1'b0;
      bus.branch_taken = 1'b0;
   endtask

   task automatic fetch_issue(input logic [31:0] w, input int waits,
                              input logic j, input logic b, input logic t);
      wait_req();
      chk("fetch_addr", {16'd0, bus.imem_addr}, {16'd0, exp_pc});
      for (int i = 0; i < waits; i++) begin
         chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
         chk("addr_hold", {16'd0, bus.imem_addr}, {16'd0, exp_pc});
         chk("valid_low_wait", {31'd0, bus.instr_valid}, 32'd0);
         @(negedge clk);
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = w;
      sb.push_back('{addr: exp_pc, word: w});
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
      issue(j, b, t);
      exp_pc = model_next(exp_pc, w, j, b, t);
   endtask

   initial begin
      vec_t vecs[9];
      int   prev_iss;
      logic [31:0] held_instr;

      vecs[0] = '{pc: 16'h0004, word: 32'hE000_FFFD, j: 0, b: 1, t: 1, exp_next: 16'h0002};
      vecs[1] = '{pc: 16'h0004, word: 32'hE000_FFFD, j: 0, b: 1, t: 0, exp_next: 16'h0005};
      vecs[2] = '{pc: 16'h0010, word: 32'hF000_0100, j: 1, b: 1, t: 1, exp_next: 16'h0100};
      vecs[3] = '{pc: 16'hFFFF, word: 32'h2000_0000, j: 0, b: 0, t: 0, exp_next: 16'h0000};
      vecs[4] = '{pc: 16'hFFFE, word: 32'hE000_0005, j: 0, b: 1, t: 1, exp_next: 16'h0004};
      vecs[5] = '{pc: 16'h0002, word: 32'hE000_FFF0, j: 0, b: 1, t: 1, exp_next: 16'hFFF3};
      vecs[6] = '{pc: 16'h0020, word: 32'hE000_0010, j: 0, b: 1, t: 0, exp_next: 16'h0021};
      vecs[7] = '{pc: 16'h0030, word: 32'hF000_ABCD, j: 1, b: 0, t: 0, exp_next: 16'hABCD};
      vecs[8] = '{pc: 16'h0040, word: 32'h2000_0000, j: 0, b: 0, t: 1, exp_next: 16'h0041};

      reset = 1'b1;
      run = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.decode_ready = 1'b0;
      bus.Jump = 1'b0;
      bus.Branch = 1'b0;
      bus.branch_taken = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state, including idle with run=0
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("rst_opcode", {28'd0, bus.Opcode}, 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_pc_out", {16'd0, bus.pc_out}, 32'd0);
      exp_pc = 16'h0000;

      // sequential stream, zero-wait memory, issue every 2 cycles
      run = 1'b1;
      prev_iss = 0;
      for (int k = 0; k < 4; k++) begin
         fetch_issue({OP_ADD, 28'h0}, 0, 1'b0, 1'b0, 1'b0);
         if (k > 0) chk("issue_spacing", iss_cyc - prev_iss, 32'd2);
         prev_iss = iss_cyc;
      end

      // delayed ack at pc=5
      fetch_issue(32'h2000_0000, 0, 1'b0, 1'b0, 1'b0);
      chk("pc_before_delay", {16'd0, exp_pc}, 32'd5);
      fetch_issue(32'h8000_0005, 3, 1'b0, 1'b0, 1'b0);

      // next-PC vector table: jump to the start pc, then issue the vector
      for (int v = 0; v < 9; v++) begin
         fetch_issue({OP_JMP, 12'h0, vecs[v].pc}, 0, 1'b1, 1'b0, 1'b0);
         fetch_issue(vecs[v].word, 0, vecs[v].j, vecs[v].b, vecs[v].t);
         wait_req();
         chk($sformatf("vec%0d_next_addr", v), {16'd0, bus.imem_addr}, {16'd0, vecs[v].exp_next});
      end

      // decode stall with Jump toggling
      wait_req();
      chk("stall_fetch_addr", {16'd0, bus.imem_addr}, {16'd0, exp_pc});
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hF000_0077;
      held_instr = 32'hF000_0077;
      sb.push_back('{addr: exp_pc, word: held_instr});
      @(negedge clk);
      bus.imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.Jump = i[0];
         bus.Branch = 1'b1;
         bus.branch_taken = 1'b1;
         chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
         chk("stall_instr", bus.instr, held_instr);
         chk("stall_opcode", {28'd0, bus.Opcode}, {28'd0, OP_JMP});
         chk("stall_pc_out", {16'd0, bus.pc_out}, {16'd0, exp_pc});
         @(negedge clk);
      end
      bus.Jump = 1'b0;
      bus.Branch = 1'b0;
      bus.branch_taken = 1'b0;
      issue(1'b0, 1'b0, 1'b0);
      exp_pc = exp_pc + 16'd1;
      wait_req();
      chk("stall_next_addr", {16'd0, bus.imem_addr}, {16'd0, exp_pc});

      // run dropped during S_REQ: fetch still issues, then idle
      run = 1'b0;
      @(negedge clk);
      chk("rundrop_req_held", {31'd0, bus.imem_req}, 32'd1);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h1000_0001;
      sb.push_back('{addr: exp_pc, word: 32'h1000_0001});
      @(negedge clk);
      bus.imem_ack = 1'b0;
      issue(1'b0, 1'b0, 1'b0);
      exp_pc = exp_pc + 16'd1;
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack = 1'b1;
         chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
         chk("idle_valid", {31'd0, bus.instr_valid}, 32'd0);
         chk("idle_pc", {16'd0, bus.pc_out}, {16'd0, exp_pc});
         @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      run = 1'b1;

      // reset mid-S_REQ with an ack in the same cycle
      wait_req();
      chk("prerst_addr", {16'd0, bus.imem_addr}, {16'd0, exp_pc});
      reset = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hF000_1234;
      @(negedge clk);
      reset = 1'b0;
      bus.imem_ack = 1'b0;
      chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("midrst_pc_out", {16'd0, bus.pc_out}, 32'd0);
      chk("midrst_instr", bus.instr, 32'd0);
      exp_pc = 16'h0000;

      // recovery after reset
      fetch_issue({OP_SUB, 28'h0}, 1, 1'b0, 1'b0, 1'b0);
      wait_req();
      chk("recover_addr", {16'd0, bus.imem_addr}, 32'd1);
      chk("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
